// File: rtl/resize_nn_decim_stream_if.sv
// Stream and metadata FIFO bundle for the nearest-neighbour downscaler.
// The resizer takes the master side; the surrounding FIFOs take the slave side.
interface resize_nn_decim_stream_if #(
    parameter int DATA_W = 24,
    parameter int DIM_W  = 16
);
    logic [DATA_W-1:0] src_dout;
    logic              src_empty_n;
    logic              src_read;
    logic [DATA_W-1:0] dst_din;
    logic              dst_full_n;
    logic              dst_write;
    logic [DIM_W-1:0]  rows_c_din;
    logic              rows_c_full_n;
    logic              rows_c_write;
    logic [DIM_W-1:0]  cols_c_din;
    logic              cols_c_full_n;
    logic              cols_c_write;

    modport master (
        input  src_dout, src_empty_n, dst_full_n, rows_c_full_n, cols_c_full_n,
        output src_read, dst_din, dst_write, rows_c_din, rows_c_write,
               cols_c_din, cols_c_write
    );

    modport slave (
        output src_dout, src_empty_n, dst_full_n, rows_c_full_n, cols_c_full_n,
        input  src_read, dst_din, dst_write, rows_c_din, rows_c_write,
               cols_c_din, cols_c_write
    );
endinterface

// File: rtl/resize_nn_decim_stream.sv
// Streaming nearest-neighbour downscaler, one pixel per clock, runtime geometry.
// Row/column selection uses DDA accumulators; illegal geometry raises a sticky err.
module resize_nn_decim_stream #(
    parameter int DATA_W = 24,
    parameter int DIM_W  = 16
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             ap_start,
    input  logic             ap_continue,
    output logic             ap_done,
    output logic             ap_idle,
    output logic             ap_ready,
    output logic             err,
    input  logic [DIM_W-1:0] in_rows,
    input  logic [DIM_W-1:0] in_cols,
    input  logic [DIM_W-1:0] out_rows,
    input  logic [DIM_W-1:0] out_cols,
    resize_nn_decim_stream_if.master fifo
);
    typedef enum logic [2:0] {IDLE, META, RUN, FIN, HOLD} state_t;

    state_t            state, state_nxt;
    logic [DIM_W-1:0]  r_in_rows, r_in_cols, r_out_rows, r_out_cols;
    logic [DIM_W-1:0]  row, col;
    logic [DIM_W:0]    cacc, racc;
    logic [DIM_W:0]    c_t, r_t;
    logic              col_keep, row_keep, kept;
    logic              geom_ok, meta_go, pop, last_col, last_row;
    logic [DATA_W-1:0] pix;

    assign geom_ok = (out_rows != '0) && (out_rows <= in_rows) &&
                     (out_cols != '0) && (out_cols <= in_cols);

    // racc is constant across a row, so row_keep is effectively sampled at row start
    assign c_t      = cacc + {1'b0, r_out_cols};
    assign r_t      = racc + {1'b0, r_out_rows};
    assign col_keep = (c_t >= {1'b0, r_in_cols});
    assign row_keep = (r_t >= {1'b0, r_in_rows});
    assign kept     = row_keep & col_keep;

    assign meta_go  = fifo.rows_c_full_n & fifo.cols_c_full_n;
    assign pop      = (state == RUN) & fifo.src_empty_n & (~kept | fifo.dst_full_n);
    assign last_col = (col == r_in_cols - DIM_W'(1));
    assign last_row = (row == r_in_rows - DIM_W'(1));
    assign pix      = fifo.src_dout;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (ap_start) state_nxt = geom_ok ? META : FIN;
            META: if (meta_go) state_nxt = RUN;
            RUN:  if (pop && last_col && last_row) state_nxt = FIN;
            FIN:  state_nxt = ap_continue ? IDLE : HOLD;
            HOLD: if (ap_continue) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fifo.src_read     = pop;
        fifo.dst_write    = pop & kept;
        fifo.dst_din      = pix;
        fifo.rows_c_write = (state == META) & meta_go;
        fifo.cols_c_write = (state == META) & meta_go;
        fifo.rows_c_din   = r_out_rows;
        fifo.cols_c_din   = r_out_cols;
        ap_done           = (state == FIN) | (state == HOLD);
        ap_ready          = (state == FIN);
        ap_idle           = (state == IDLE) & ~ap_start;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_in_rows  <= '0;
            r_in_cols  <= '0;
            r_out_rows <= '0;
            r_out_cols <= '0;
            row        <= '0;
            col        <= '0;
            cacc       <= '0;
            racc       <= '0;
            err        <= 1'b0;
        end else if (state == IDLE && ap_start) begin
            r_in_rows  <= in_rows;
            r_in_cols  <= in_cols;
            r_out_rows <= out_rows;
            r_out_cols <= out_cols;
            row        <= '0;
            col        <= '0;
            cacc       <= '0;
            racc       <= '0;
            err        <= ~geom_ok;
        end else if (pop) begin
            if (last_col) begin
                col  <= '0;
                cacc <= '0;
                row  <= row + DIM_W'(1);
                racc <= row_keep ? r_t - {1'b0, r_in_rows} : r_t;
            end else begin
                col  <= col + DIM_W'(1);
                cacc <= col_keep ? c_t - {1'b0, r_in_cols} : c_t;
            end
        end
    end
endmodule

// File: doc/resize_nn_decim_stream.md
Name: resize_nn_decim_stream

Overview:
- Parametrised streaming nearest-neighbour downscaler for the preprocessing pipeline, one pixel per clock.
- Generalises the fixed-geometry resize stage: pixel width is a parameter, frame dimensions are taken at runtime, and illegal geometry is detected.
- Sits between the colour-convert stream and the normalise stage.
- On each start it writes out_rows/out_cols to downstream metadata FIFOs, then streams the decimated frame.

Parameters:
- DATA_W, 24, pixel width in bits (channels x bits per channel).
- DIM_W, 16, width of all dimension inputs and metadata outputs.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- ap_start  in  1  start request, level.
- ap_continue  in  1  acknowledges done (ap_ctrl_chain).
- ap_done  out  1  frame complete.
- ap_idle  out  1  block idle.
- ap_ready  out  1  ready for the next start.
- err  out  1  last frame had illegal geometry; sticky until next start.
- in_rows  in  DIM_W  source height; sampled at start.
- in_cols  in  DIM_W  source width.
- out_rows  in  DIM_W  destination height.
- out_cols  in  DIM_W  destination width.
- src_dout  in  DATA_W  source FIFO data.
- src_empty_n  in  1  source FIFO not empty.
- src_read  out  1  source FIFO pop.
- dst_din  out  DATA_W  destination FIFO data.
- dst_full_n  in  1  destination FIFO not full.
- dst_write  out  1  destination FIFO push.
- rows_c_din  out  DIM_W  metadata out_rows.
- rows_c_full_n  in  1  rows metadata FIFO not full.
- rows_c_write  out  1  rows metadata push.
- cols_c_din  out  DIM_W  metadata out_cols.
- cols_c_full_n  in  1  cols metadata FIFO not full.
- cols_c_write  out  1  cols metadata push.

Behaviour:
- Reset (async assert, sync deassert): FSM=IDLE, all counters and accumulators 0, err=0.
- Reset values of outputs: src_read, dst_write, rows_c_write, cols_c_write, ap_done and ap_ready are 0. ap_idle follows IDLE, so it is 1 while ap_start=0.
- Reset mid-frame: abort immediately. No partial-frame recovery; upstream and downstream FIFOs are flushed by the system.
- FSM states: IDLE, META, RUN, FIN, HOLD.
- IDLE: ap_idle = !ap_start.
  - On ap_start=1, register the four dimensions and clear err.
  - Legal geometry (0<out_rows<=in_rows and 0<out_cols<=in_cols): go to META.
  - Otherwise: set err=1 and go to FIN; no FIFO access.
- META: when rows_c_full_n & cols_c_full_n, assert both *_write for exactly one cycle, then go to RUN. Never write one metadata FIFO without the other. din values are the registered out_rows/out_cols.
- RUN:
  - Current pixel is kept iff row_keep & col_keep.
  - src_read = src_empty_n & (!kept | dst_full_n).
  - dst_write = src_read & kept.
  - dst_din = src_dout (combinational, zero latency).
  - Dropped pixels are consumed regardless of dst_full_n.
- Column DDA (cacc, DIM_W+1 bits, cleared at row start), on each pop: t = cacc + out_cols.
  - col_keep = (t >= in_cols).
  - cacc <= col_keep ? t - in_cols : t.
- Row DDA (racc, DIM_W+1 bits, cleared at frame start):
  - row_keep = (racc + out_rows >= in_rows), evaluated on racc at row start.
  - racc updates the same way at the pop of the last column.
- Decimation result: exactly out_cols pixels per kept row and exactly out_rows kept rows. Input column j is kept iff floor((j+1)*out_cols/in_cols) > floor(j*out_cols/in_cols); rows follow the same rule. Equal dims give passthrough.
- Counters: col (0..in_cols-1) wraps at in_cols-1 and increments row. The pop with row=in_rows-1 and col=in_cols-1 moves to FIN.
- FIN: ap_done=1 and ap_ready=1 for one cycle. ap_continue=1 -> IDLE; else -> HOLD.
- HOLD: ap_done=1, ap_ready=0; on ap_continue=1 -> IDLE.
  - ap_continue in the same cycle as FIN clears done, so there is no HOLD cycle.
  - A new ap_start is ignored until back in IDLE.
- Dimension inputs may change freely outside IDLE.

Test Plan:
- in 4x4, out 2x2, src pixels 0..15, sinks always ready -> rows_c=2, cols_c=2 written once; dst receives 5,7,13,15; 16 pops; ap_done one cycle after the final pop.
- in 3x5, out 3x5 -> passthrough: 15 pixels out equal to input order; err=0.
- in 6x6, out 4x3, dst_full_n toggling every other cycle, src bursty -> exactly 12 writes, matching a golden floor-rule model; no pop of a kept pixel while dst_full_n=0; dropped pixels still pop.
- rows_c_full_n=0 for 10 cycles in META -> no writes, no pops; then both metadata writes in the same single cycle and streaming begins.
- out_cols=5 > in_cols=4 (also out_rows=0) -> err=1, zero FIFO activity, ap_done asserted; err clears on the next legal start.
- ap_continue held 0 at end -> ap_done stays 1 in HOLD and ap_start is ignored. Also: ap_rst_n pulsed mid-RUN -> all outputs 0 within the reset cycle, FSM in IDLE.
